// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter for a shared snoopy MESI bus: broadcasts the winning request,
// gathers snoop acks/hit/flush, sequences the memory fill and signals completion.
module coherence_bus_arbiter #(
    parameter int unsigned NCORES  = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NCORES-1:0]            req_i,
    input  logic [2*NCORES-1:0]          req_msg_i,
    input  logic [ADDR_W*NCORES-1:0]     req_addr_i,
    output logic [NCORES-1:0]            gnt_o,
    output logic                         bus_valid_o,
    output logic [1:0]                   bus_msg_o,
    output logic [ADDR_W-1:0]            bus_addr_o,
    output logic [$clog2(NCORES)-1:0]    bus_src_o,
    input  logic [NCORES-1:0]            snoop_ack_i,
    input  logic [NCORES-1:0]            snoop_hit_i,
    input  logic [NCORES-1:0]            flush_i,
    output logic                         mem_req_o,
    input  logic                         mem_ack_i,
    output logic [NCORES-1:0]            done_o,
    output logic                         shared_o,
    output logic                         err_o
);

    localparam int unsigned SRC_W = $clog2(NCORES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] MSG_NA  = 2'b00;
    localparam logic [1:0] MSG_INV = 2'b01;
    localparam logic [1:0] MSG_RM  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_MEM, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SRC_W-1:0]    r_src;
    logic [SRC_W-1:0]    r_ptr;
    logic [1:0]          r_msg;
    logic [ADDR_W-1:0]   r_addr;
    logic [NCORES-1:0]   r_ack_mask;
    logic                r_hit;
    logic                r_flush;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic [1:0]          w_msg_arr  [NCORES];
    logic [ADDR_W-1:0]   w_addr_arr [NCORES];
    logic                w_found;
    logic [SRC_W-1:0]    w_win;
    logic [SRC_W-1:0]    w_idx;
    logic [NCORES-1:0]   w_src_bit;
    logic [NCORES-1:0]   w_new_ack;
    logic                w_all_acked;
    logic                w_timeout;

    for (genvar g = 0; g < NCORES; g++) begin : g_unpack
        assign w_msg_arr[g]  = req_msg_i[2*g +: 2];
        assign w_addr_arr[g] = req_addr_i[ADDR_W*g +: ADDR_W];
    end

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NCORES; i++) begin
            w_idx = SRC_W'((32'(r_ptr) + i) % NCORES);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_src_bit   = NCORES'(1) << r_src;
    assign w_new_ack   = snoop_ack_i & ~w_src_bit;
    assign w_all_acked = ((r_ack_mask | w_new_ack) == ~w_src_bit);
    assign w_timeout   = !w_all_acked && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = (w_msg_arr[w_win] == MSG_NA) ? S_DONE : S_BCAST;
            S_BCAST: w_state_next = S_SNOOP;
            S_SNOOP: if (w_all_acked || w_timeout) w_state_next = (r_msg == MSG_INV) ? S_DONE : S_MEM;
            S_MEM:   if (mem_ack_i) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_src      <= '0;
            r_ptr      <= SRC_W'(NCORES - 1);
            r_msg      <= '0;
            r_addr     <= '0;
            r_ack_mask <= '0;
            r_hit      <= 1'b0;
            r_flush    <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_src  <= w_win;
                        r_msg  <= w_msg_arr[w_win];
                        r_addr <= w_addr_arr[w_win];
                    end
                end
                S_BCAST: begin
                    r_ack_mask <= '0;
                    r_hit      <= 1'b0;
                    r_flush    <= 1'b0;
                    r_cnt      <= '0;
                end
                S_SNOOP: begin
                    r_ack_mask <= r_ack_mask | w_new_ack;
                    r_hit      <= r_hit   | (|(snoop_hit_i & w_new_ack));
                    r_flush    <= r_flush | (|(flush_i & w_new_ack));
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (w_timeout) r_err <= 1'b1;
                end
                S_DONE:  r_ptr <= r_src;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt_o       = '0;
        bus_valid_o = 1'b0;
        bus_msg_o   = '0;
        mem_req_o   = 1'b0;
        done_o      = '0;
        shared_o    = 1'b0;
        case (r_state)
            S_BCAST: begin
                gnt_o       = w_src_bit;
                bus_valid_o = 1'b1;
                bus_msg_o   = r_msg;
            end
            S_MEM: mem_req_o = 1'b1;
            S_DONE: begin
                done_o   = w_src_bit;
                shared_o = (r_hit | r_flush) && (r_msg == MSG_RM);
            end
            default: ;
        endcase
    end

    assign bus_addr_o = r_addr;
    assign bus_src_o  = r_src;
    assign err_o      = r_err;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized bench for coherence_bus_arbiter against a transaction-level model of
// round-robin selection, snoop completion/timeout, memory fill and the shared flag.
module tb_coherence_bus_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NC-1:0]     req_i;
    logic [2*NC-1:0]   req_msg_i;
    logic [AW*NC-1:0]  req_addr_i;
    logic [NC-1:0]     gnt_o;
    logic              bus_valid_o;
    logic [1:0]        bus_msg_o;
    logic [AW-1:0]     bus_addr_o;
    logic [1:0]        bus_src_o;
    logic [NC-1:0]     snoop_ack_i;
    logic [NC-1:0]     snoop_hit_i;
    logic [NC-1:0]     flush_i;
    logic              mem_req_o;
    logic              mem_ack_i;
    logic [NC-1:0]     done_o;
    logic              shared_o;
    logic              err_o;

    always #5 clk = ~clk;

    coherence_bus_arbiter #(
        .NCORES (NC),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .req_msg_i  (req_msg_i),
        .req_addr_i (req_addr_i),
        .gnt_o      (gnt_o),
        .bus_valid_o(bus_valid_o),
        .bus_msg_o  (bus_msg_o),
        .bus_addr_o (bus_addr_o),
        .bus_src_o  (bus_src_o),
        .snoop_ack_i(snoop_ack_i),
        .snoop_hit_i(snoop_hit_i),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_ack_i  (mem_ack_i),
        .done_o     (done_o),
        .shared_o   (shared_o),
        .err_o      (err_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bit              pending [NC];
    logic [1:0]      pmsg    [NC];
    logic [AW-1:0]   paddr   [NC];
    int unsigned     m_ptr;
    bit              m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned c, input logic [1:0] msg, input logic [AW-1:0] addr);
        pending[c] = 1'b1;
        pmsg[c]    = msg;
        paddr[c]   = addr;
        req_i[c]   = 1'b1;
        req_msg_i[2*c +: 2]   = msg;
        req_addr_i[AW*c +: AW] = addr;
    endtask

    task automatic drop_req(input int unsigned c);
        pending[c] = 1'b0;
        req_i[c]   = 1'b0;
    endtask

    function automatic int unsigned rr_pick();
        for (int unsigned k = 1; k <= NC; k++) begin
            if (pending[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
        end
        return NC;
    endfunction

    task automatic noise();
        snoop_ack_i = NC'($urandom);
        snoop_hit_i = NC'($urandom);
        flush_i     = NC'($urandom);
        mem_ack_i   = 1'($urandom);
    endtask

    // Entered at the falling edge of an IDLE cycle; returns at the falling edge of DONE,
    // or right after asserting reset during the first MEM cycle when abort_mem is set.
    task automatic run_txn(input bit all_rm, input bit abort_mem, output bit aborted);
        int unsigned w, n, m;
        logic [1:0]    msg;
        logic [AW-1:0] addr;
        int            d  [NC];
        bit            hc [NC];
        bit            fc [NC];
        bit            tmo, exp_hit;
        logic [NC-1:0] av, hv, fv;
        aborted = 1'b0;
        check_eq("idle_quiet", {bus_valid_o, mem_req_o, done_o, gnt_o}, '0);
        for (int unsigned c = 0; c < NC; c++) begin
            if (!pending[c]) begin
                if (all_rm) set_req(c, 2'b11, $urandom);
                else if ($urandom_range(0, 2) == 0) set_req(c, 2'($urandom_range(0, 3)), $urandom);
            end
        end
        if (rr_pick() == NC) set_req($urandom_range(0, NC - 1), 2'($urandom_range(0, 3)), $urandom);
        noise();
        w    = rr_pick();
        msg  = pmsg[w];
        addr = paddr[w];
        @(negedge clk);
        if (msg == 2'b00) begin
            check_eq("na_done", done_o, NC'(1) << w);
            check_eq("na_nobus", {bus_valid_o, shared_o}, '0);
            check_eq("na_err", err_o, m_err);
        end else begin
            check_eq("bcast_valid", bus_valid_o, 1'b1);
            check_eq("bcast_gnt", gnt_o, NC'(1) << w);
            check_eq("bcast_msg", bus_msg_o, msg);
            check_eq("bcast_addr", bus_addr_o, addr);
            check_eq("bcast_src", bus_src_o, w);
            noise();
            tmo = 1'b0;
            n   = 0;
            for (int unsigned c = 0; c < NC; c++) begin
                int unsigned r;
                r = $urandom_range(0, 11);
                d[c]  = (c == w) ? -1 : (r == 0) ? -1 : (r == 1) ? int'(TO) : int'(1 + r % 4);
                fc[c] = ($urandom_range(0, 3) == 0);
                hc[c] = fc[c] | 1'($urandom);
                if (c != w && d[c] < 0) tmo = 1'b1;
                if (d[c] > int'(n)) n = d[c];
            end
            if (tmo) n = TO;
            exp_hit = 1'b0;
            for (int unsigned c = 0; c < NC; c++)
                if (d[c] > 0 && d[c] <= int'(n) && (hc[c] || fc[c])) exp_hit = 1'b1;
            for (int unsigned k = 1; k <= n; k++) begin
                @(negedge clk);
                check_eq("snoop_quiet", {bus_valid_o, mem_req_o, done_o}, '0);
                av = '0; hv = NC'($urandom); fv = NC'($urandom);
                for (int unsigned c = 0; c < NC; c++) begin
                    if (c == w) av[c] = 1'($urandom);
                    else if (d[c] == int'(k)) begin
                        av[c] = 1'b1; hv[c] = hc[c]; fv[c] = fc[c];
                    end else begin
                        hv[c] = 1'b0; fv[c] = 1'b0;
                    end
                end
                snoop_ack_i = av; snoop_hit_i = hv; flush_i = fv;
                mem_ack_i   = 1'($urandom);
                if (k == 1 && $urandom_range(0, 7) == 0) drop_req(w);
            end
            m_err = m_err | tmo;
            @(negedge clk);
            if (msg != 2'b01) begin
                m = $urandom_range(1, 4);
                for (int unsigned j = 1; j <= m; j++) begin
                    check_eq("mem_req", {mem_req_o, done_o}, {1'b1, NC'(0)});
                    noise();
                    if (abort_mem) begin
                        rst_ni = 1'b0;
                        snoop_ack_i = '0; snoop_hit_i = '0; flush_i = '0; mem_ack_i = 1'b0;
                        if (!pending[0]) set_req(0, 2'b01, $urandom);
                        aborted = 1'b1;
                        return;
                    end
                    mem_ack_i = (j == m);
                    if (j < m) @(negedge clk);
                end
                @(negedge clk);
            end
            check_eq("done", done_o, NC'(1) << w);
            check_eq("done_nomem", mem_req_o, 1'b0);
            check_eq("shared", shared_o, (msg == 2'b11) && exp_hit);
            check_eq("err", err_o, m_err);
            check_eq("done_addr", bus_addr_o, addr);
        end
        if (pending[w]) drop_req(w);
        m_ptr = w;
        noise();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ab;
        rst_ni = 1'b0;
        req_i = '0; req_msg_i = '0; req_addr_i = '0;
        snoop_ack_i = '0; snoop_hit_i = '0; flush_i = '0; mem_ack_i = 1'b0;
        for (int unsigned c = 0; c < NC; c++) pending[c] = 1'b0;
        m_ptr = NC - 1;
        m_err = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {gnt_o, bus_valid_o, bus_msg_o, bus_addr_o, bus_src_o,
                                mem_req_o, done_o, shared_o, err_o}, '0);
        rst_ni = 1'b1;
        for (int t = 0; t < 70; t++) begin
            run_txn(t < 6, t == 40, ab);
            if (ab) begin
                @(negedge clk);
                check_eq("midreset_outs", {gnt_o, bus_valid_o, bus_msg_o, bus_addr_o, bus_src_o,
                                           mem_req_o, done_o, shared_o, err_o}, '0);
                m_ptr  = NC - 1;
                m_err  = 1'b0;
                rst_ni = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
